mux_scan_nto1: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer. It is the successor to the team's fixed 8:1 combinational mux. It adds a valid/ready output handshake, a registered output stage, and an auto-scan mode that round-robins through the channels with a programmable dwell count. It sits between groups of parallel producers and a single downstream consumer, such as a serial link or a logging path.

---
 rtl/mux_pkg.sv | 23 ++
 rtl/mux_scan_nto1_scan_ptr.sv | 52 +++++
 rtl/mux_scan_nto1.sv | 103 ++++++++++
 tb/tb_mux_scan_nto1.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning N:1 mux.
// Channel-index helper is sized for up to 64 channels.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_e;

    // Wraps at n-1 so non-power-of-2 channel counts never overrun.
    function automatic logic [6:0] next_ch(
        input logic [6:0] c,
        input logic [6:0] n
    );
        return (c == n - 7'd1) ? 7'd0 : c + 7'd1;
    endfunction

endpackage

// File: rtl/mux_scan_nto1_scan_ptr.sv
// Round-robin scan pointer with per-channel dwell counter.
// clear forces the pointer to channel 0 for the current beat.
module scan_ptr
    import mux_pkg::*;
#(
    parameter  int N_CH    = 8,
    parameter  int DWELL_W = 8,
    localparam int SEL_W   = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clear,
    input  logic               valid_at_ptr,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   ptr
);

    logic [SEL_W-1:0]   ptr_q, ptr_d, ptr_cur, ptr_nxt;
    logic [DWELL_W-1:0] cnt_q, cnt_d, cnt_cur;

    always_comb begin
        ptr_cur = clear ? '0 : ptr_q;
        cnt_cur = clear ? '0 : cnt_q;
        ptr_nxt = SEL_W'(next_ch(7'(ptr_cur), 7'(N_CH)));
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (en) begin
            if (valid_at_ptr && (cnt_cur != dwell)) begin
                ptr_d = ptr_cur;
                cnt_d = cnt_cur + 1'b1;
            end else begin
                // Dwell exhausted, or empty channel skipped.
                ptr_d = ptr_nxt;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign ptr = ptr_cur;

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N:1 mux with valid/ready output and round-robin scan mode.
module mux_scan_nto1
    import mux_pkg::*;
#(
    parameter  int N_CH    = 8,
    parameter  int W       = 8,
    parameter  int DWELL_W = 8,
    localparam int SEL_W   = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic [N_CH-1:0]     in_valid,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SEL_W-1:0]    out_ch,
    output logic                sel_err
);

    state_e           state_q, state_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             sel_err_q, sel_err_d;

    logic             cap, is_scan, sel_ok;
    logic             scan_en, scan_clr;
    logic [SEL_W-1:0] scan_ch, ch_idx;
    logic [W-1:0]     data_at_ch;
    logic             valid_at_ch;

    always_comb begin
        cap         = !out_valid_q || out_ready;
        is_scan     = (mode == MODE_SCAN);
        sel_ok      = {1'b0, sel} < (SEL_W+1)'(N_CH);
        scan_en     = cap && is_scan;
        scan_clr    = scan_en && (state_q == ST_MANUAL);
        ch_idx      = is_scan ? scan_ch : sel;
        data_at_ch  = in_data[int'(ch_idx)*W +: W];
        valid_at_ch = in_valid[ch_idx];
    end

    scan_ptr #(
        .N_CH    (N_CH),
        .DWELL_W (DWELL_W)
    ) u_scan_ptr (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (scan_en),
        .clear        (scan_clr),
        .valid_at_ptr (valid_at_ch),
        .dwell        (dwell),
        .ptr          (scan_ch)
    );

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        sel_err_d   = 1'b0;
        if (cap) begin
            state_d = is_scan ? ST_SCAN : ST_MANUAL;
            if (is_scan || sel_ok) begin
                out_valid_d = valid_at_ch;
                if (valid_at_ch) begin
                    out_data_d = data_at_ch;
                    out_ch_d   = ch_idx;
                end
            end else begin
                // Out-of-range manual select: drop the beat, keep data/ch.
                out_valid_d = 1'b0;
                sel_err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_MANUAL;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Self-checking bench: 8- and 5-channel instances, scoreboard of beats.
module tb_mux_scan_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       mode;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] dwell;

    logic [63:0] in_data8;
    logic [7:0]  in_valid8;
    logic [7:0]  o8_data;
    logic        o8_valid;
    logic [2:0]  o8_ch;
    logic        o8_err;

    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [7:0]  o5_data;
    logic        o5_valid;
    logic [2:0]  o5_ch;
    logic        o5_err;

    mux_scan_nto1 #(.N_CH(8), .W(8), .DWELL_W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .mode      (mode),
        .sel       (sel),
        .dwell     (dwell),
        .out_data  (o8_data),
        .out_valid (o8_valid),
        .out_ready (out_ready),
        .out_ch    (o8_ch),
        .sel_err   (o8_err)
    );

    mux_scan_nto1 #(.N_CH(5), .W(8), .DWELL_W(8)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .mode      (mode),
        .sel       (sel),
        .dwell     (dwell),
        .out_data  (o5_data),
        .out_valid (o5_valid),
        .out_ready (out_ready),
        .out_ch    (o5_ch),
        .sel_err   (o5_err)
    );

    typedef struct {
        bit         use5;
        bit         v;
        bit         chk;
        logic [7:0] d;
        logic [2:0] ch;
        bit         err;
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] d;
    } mvec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(bit use5, bit v, bit chk,
                        logic [7:0] d, logic [2:0] ch, bit err);
        exp_t e;
        e.use5 = use5;
        e.v    = v;
        e.chk  = chk;
        e.d    = d;
        e.ch   = ch;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic pop_check(string tag);
        exp_t       e;
        logic [7:0] gd;
        logic       gv;
        logic [2:0] gc;
        logic       ge;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got 1 want 0", tag);
            return;
        end
        e  = sb.pop_front();
        gd = e.use5 ? o5_data  : o8_data;
        gv = e.use5 ? o5_valid : o8_valid;
        gc = e.use5 ? o5_ch    : o8_ch;
        ge = e.use5 ? o5_err   : o8_err;
        cmp({tag, ".valid"}, 32'(gv), 32'(e.v));
        cmp({tag, ".err"},   32'(ge), 32'(e.err));
        if (e.chk) begin
            cmp({tag, ".data"}, 32'(gd), 32'(e.d));
            cmp({tag, ".ch"},   32'(gc), 32'(e.ch));
        end
    endtask

    task automatic check_zero(string tag);
        cmp({tag, ".d8"}, 32'(o8_data),  0);
        cmp({tag, ".v8"}, 32'(o8_valid), 0);
        cmp({tag, ".c8"}, 32'(o8_ch),    0);
        cmp({tag, ".e8"}, 32'(o8_err),   0);
        cmp({tag, ".d5"}, 32'(o5_data),  0);
        cmp({tag, ".v5"}, 32'(o5_valid), 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        sel       = 3'd0;
        dwell     = 8'd0;
        in_valid8 = '1;
        in_valid5 = '1;
        tick();
        check_zero("reset");
        rst_n = 1'b1;
    endtask

    mvec_t tv[8];
    int    scan5_exp[12];
    int    skip8_exp[9];

    initial begin
        tv[0] = '{3'd0, 8'h10};
        tv[1] = '{3'd1, 8'h11};
        tv[2] = '{3'd2, 8'h12};
        tv[3] = '{3'd3, 8'h13};
        tv[4] = '{3'd4, 8'h14};
        tv[5] = '{3'd5, 8'h15};
        tv[6] = '{3'd6, 8'h16};
        tv[7] = '{3'd7, 8'h17};
        scan5_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};
        skip8_exp = '{0, -1, 2, -1, -1, 5, -1, 7, 0};

        for (int k = 0; k < 8; k++) in_data8[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 5; k++) in_data5[k*8 +: 8] = 8'h10 + 8'(k);

        // Manual select sweep with an async reset in the middle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            sel = tv[i].sel;
            push(0, 1, 1, tv[i].d, tv[i].sel, 0);
            tick();
            pop_check($sformatf("man%0d", i));
            if (i == 4) begin
                rst_n = 1'b0;
                #2;
                check_zero("async_rst");
                #1;
                rst_n = 1'b1;
            end
        end

        // Stall hold.
        do_reset();
        sel = 3'd3;
        push(0, 1, 1, 8'h13, 3'd3, 0);
        tick();
        pop_check("stall_pre");
        out_ready = 1'b0;
        sel       = 3'd5;
        for (int i = 0; i < 4; i++) begin
            push(0, 1, 1, 8'h13, 3'd3, 0);
            tick();
            pop_check($sformatf("stall%0d", i));
        end
        out_ready = 1'b1;
        push(0, 1, 1, 8'h15, 3'd5, 0);
        tick();
        pop_check("stall_post");

        // Scan, 5 channels, dwell 1.
        do_reset();
        dwell = 8'd1;
        mode  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push(1, 1, 1, 8'h10 + 8'(scan5_exp[i]), 3'(scan5_exp[i]), 0);
            tick();
            pop_check($sformatf("scan5_%0d", i));
        end

        // Scan skipping empty channels.
        do_reset();
        in_valid8 = 8'b1010_0101;
        mode      = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (skip8_exp[i] < 0) push(0, 0, 0, 8'h00, 3'd0, 0);
            else push(0, 1, 1, 8'h10 + 8'(skip8_exp[i]),
                      3'(skip8_exp[i]), 0);
            tick();
            pop_check($sformatf("skip%0d", i));
        end

        // Manual select out of range on the 5-channel instance.
        do_reset();
        sel = 3'd2;
        push(1, 1, 1, 8'h12, 3'd2, 0);
        tick();
        pop_check("oor_pre");
        sel = 3'd6;
        push(1, 0, 1, 8'h12, 3'd2, 1);
        tick();
        pop_check("oor_err");
        sel = 3'd2;
        push(1, 1, 1, 8'h12, 3'd2, 0);
        tick();
        pop_check("oor_post");

        // Mode switch while stalled in scan at channel 3.
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(0, 1, 1, 8'h10 + 8'(i), 3'(i), 0);
            tick();
            pop_check($sformatf("sw_scan%0d", i));
        end
        out_ready = 1'b0;
        mode      = 1'b0;
        sel       = 3'd1;
        for (int i = 0; i < 2; i++) begin
            push(0, 1, 1, 8'h13, 3'd3, 0);
            tick();
            pop_check($sformatf("sw_hold%0d", i));
        end
        out_ready = 1'b1;
        push(0, 1, 1, 8'h11, 3'd1, 0);
        tick();
        pop_check("sw_manual");
        mode = 1'b1;
        push(0, 1, 1, 8'h10, 3'd0, 0);
        tick();
        pop_check("sw_rescan0");
        push(0, 1, 1, 8'h11, 3'd1, 0);
        tick();
        pop_check("sw_rescan1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
